// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, Status/Cause field positions and write masks.
package cp0_pkg;

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int unsigned STATUS_IE     = 0;
    localparam int unsigned STATUS_EXL    = 1;
    localparam int unsigned STATUS_IM_LSB = 8;
    localparam int unsigned STATUS_BEV    = 22;

    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB  = 8;
    localparam int unsigned CAUSE_TI      = 30;
    localparam int unsigned CAUSE_BD      = 31;

    localparam logic [31:0] ENTRYHI_MASK = 32'hFFFF_E0FF;
    localparam logic [31:0] ENTRYLO_MASK = 32'h03FF_FFFF;

    // EntryLo layout: {0, PFN, C, D, V, G}
    function automatic logic [31:0] entrylo_pack(input logic [19:0] pfn, input logic [2:0] c,
                                                 input logic d, input logic v, input logic g);
        return {6'b0, pfn, c, d, v, g};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with a prescaling divider and sticky timer-interrupt flag.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int unsigned    DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [31:0]      count_inc;

    assign tick      = (div_q == DIV_LAST);
    assign count_inc = count + 32'd1;

    // Free-running prescaler; an mtc0 Count does not disturb its phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count_we) begin
            count <= wdata;
        end else if (tick) begin
            count <= count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            compare <= '0;
        end else if (compare_we) begin
            compare <= wdata;
        end
    end

    // The match is taken on the tick that moves Count onto Compare, so the
    // reset state (Count == Compare == 0) does not raise a spurious interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            ti <= 1'b0;
        end else if (compare_we) begin
            ti <= 1'b0;
        end else if (tick && !count_we && (count_inc == compare)) begin
            ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file beside WB: Status/Cause/EPC/BadVAddr, timer and interrupt logic.
// Define CP0_TLB_EN to implement Index/EntryHi/EntryLo0/EntryLo1 and the tlbp/tlbr ports.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int unsigned  TLBNUM    = 16,
    parameter int unsigned  EXT_INT_W = 6,
    parameter int unsigned  COUNT_DIV = 2,
    localparam int unsigned INDEX_W   = $clog2(TLBNUM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [EXT_INT_W-1:0] ext_int,
    input  logic                 mtc0_we,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_wdata,
    output logic [31:0]          cp0_rdata,
    input  logic                 exc_commit,
    input  logic [4:0]           exc_code,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_badv_we,
    input  logic [31:0]          exc_badvaddr,
    input  logic                 eret_commit,
    output logic [31:0]          epc_out,
    output logic                 status_exl,
    output logic                 int_pending,
    input  logic                 tlbp_we,
    input  logic                 tlbp_found,
    input  logic [INDEX_W-1:0]   tlbp_index,
    input  logic                 tlbr_we,
    input  logic [18:0]          r_vpn2,
    input  logic [7:0]           r_asid,
    input  logic                 r_g,
    input  logic [19:0]          r_pfn0,
    input  logic [2:0]           r_c0,
    input  logic                 r_d0,
    input  logic                 r_v0,
    input  logic [19:0]          r_pfn1,
    input  logic [2:0]           r_c1,
    input  logic                 r_d1,
    input  logic                 r_v1,
    output logic [31:0]          entryhi_out,
    output logic [31:0]          entrylo0_out,
    output logic [31:0]          entrylo1_out,
    output logic [INDEX_W-1:0]   index_out
);

    logic        mtc0_ok;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;
    logic [5:0]  ext_pad;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic [31:0] index_rd;

    // A same-cycle exception kills the mtc0 in WB.
    assign mtc0_ok = mtc0_we & ~exc_commit;
    assign ext_pad = 6'(ext_int);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (mtc0_ok && (cp0_addr == CP0_COUNT)),
        .compare_we (mtc0_ok && (cp0_addr == CP0_COMPARE)),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Status: later assignments encode exc > eret > mtc0 for EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
        end else begin
            if (mtc0_ok && (cp0_addr == CP0_STATUS)) begin
                im_q  <= cp0_wdata[STATUS_IM_LSB +: 8];
                exl_q <= cp0_wdata[STATUS_EXL];
                ie_q  <= cp0_wdata[STATUS_IE];
            end
            if (exc_commit) begin
                exl_q <= 1'b1;
            end else if (eret_commit) begin
                exl_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
        end else begin
            ip_hw_q <= ext_pad | {ti, 5'b0};
            if (mtc0_ok && (cp0_addr == CP0_CAUSE)) begin
                ip_sw_q <= cp0_wdata[CAUSE_IP_LSB +: 2];
            end
            if (exc_commit) begin
                exc_code_q <= exc_code;
                if (!exl_q) begin
                    bd_q <= exc_bd;
                end
            end
        end
    end

    // EPC is only captured for the first exception of a nest.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q <= '0;
        end else if (exc_commit) begin
            if (!exl_q) begin
                epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
            end
        end else if (mtc0_ok && (cp0_addr == CP0_EPC)) begin
            epc_q <= cp0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= '0;
        end else if (exc_commit && exc_badv_we) begin
            badvaddr_q <= exc_badvaddr;
        end
    end

`ifdef CP0_TLB_EN
    logic [31:0]        entryhi_q;
    logic [31:0]        entrylo0_q;
    logic [31:0]        entrylo1_q;
    logic               index_p_q;
    logic [INDEX_W-1:0] index_q;

    // A tlbr result overrides a same-cycle mtc0 to the entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            entryhi_q  <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
        end else if (tlbr_we) begin
            entryhi_q  <= {r_vpn2, 5'b0, r_asid};
            entrylo0_q <= entrylo_pack(r_pfn0, r_c0, r_d0, r_v0, r_g);
            entrylo1_q <= entrylo_pack(r_pfn1, r_c1, r_d1, r_v1, r_g);
        end else if (mtc0_ok) begin
            if (cp0_addr == CP0_ENTRYHI) begin
                entryhi_q <= cp0_wdata & ENTRYHI_MASK;
            end
            if (cp0_addr == CP0_ENTRYLO0) begin
                entrylo0_q <= cp0_wdata & ENTRYLO_MASK;
            end
            if (cp0_addr == CP0_ENTRYLO1) begin
                entrylo1_q <= cp0_wdata & ENTRYLO_MASK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_p_q <= 1'b0;
            index_q   <= '0;
        end else if (tlbp_we) begin
            index_p_q <= ~tlbp_found;
            if (tlbp_found) begin
                index_q <= tlbp_index;
            end
        end else if (mtc0_ok && (cp0_addr == CP0_INDEX)) begin
            index_q <= cp0_wdata[INDEX_W-1:0];
        end
    end

    assign entryhi_out  = entryhi_q;
    assign entrylo0_out = entrylo0_q;
    assign entrylo1_out = entrylo1_q;
    assign index_out    = index_q;
    assign index_rd     = {index_p_q, {(31-INDEX_W){1'b0}}, index_q};
`else
    logic unused_tlb;

    assign entryhi_out  = '0;
    assign entrylo0_out = '0;
    assign entrylo1_out = '0;
    assign index_out    = '0;
    assign index_rd     = '0;
    assign unused_tlb   = ^{tlbp_we, tlbp_found, tlbp_index, tlbr_we, r_vpn2, r_asid, r_g,
                            r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
`endif

    always_comb begin
        status_rd                          = '0;
        status_rd[STATUS_BEV]              = 1'b1;
        status_rd[STATUS_IM_LSB +: 8]      = im_q;
        status_rd[STATUS_EXL]              = exl_q;
        status_rd[STATUS_IE]               = ie_q;

        cause_rd                           = '0;
        cause_rd[CAUSE_BD]                 = bd_q;
        cause_rd[CAUSE_TI]                 = ti;
        cause_rd[CAUSE_IP_LSB +: 8]        = {ip_hw_q, ip_sw_q};
        cause_rd[CAUSE_EXC_LSB +: 5]       = exc_code_q;
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_INDEX:    cp0_rdata = index_rd;
            CP0_ENTRYLO0: cp0_rdata = entrylo0_out;
            CP0_ENTRYLO1: cp0_rdata = entrylo1_out;
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count;
            CP0_ENTRYHI:  cp0_rdata = entryhi_out;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = status_rd;
            CP0_CAUSE:    cp0_rdata = cause_rd;
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign epc_out     = epc_q;
    assign status_exl  = exl_q;
    assign int_pending = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Standalone, parametrised CP0 coprocessor register file, split out of the write-back stage.
- Holds Status, Cause, EPC, Count, Compare, BadVAddr and, optionally, the TLB-management registers.
- Sits beside wb_stage. WB drives exception/eret/mtc0 commits and reads mfc0 data; the front end consumes epc_out and int_pending.
- Adds over the previous in-stage CP0: a configurable timer divider, a configurable external-interrupt width, a defined same-cycle event priority, and tlbp/tlbr support.

Parameters:
- TLBNUM, 16, number of TLB entries; INDEX_W = clog2(TLBNUM)
- EXT_INT_W, 6, external interrupt lines (1..6); ext_int[i] maps to Cause.IP[2+i]
- COUNT_DIV, 2, Count increments once every COUNT_DIV clk cycles (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ext_int  in  EXT_INT_W  external interrupt request levels
- mtc0_we  in  1  commit an mtc0 write (WB, valid, no exception)
- cp0_addr  in  5  register number for mtc0/mfc0
- cp0_wdata  in  32  mtc0 write data
- cp0_rdata  out  32  mfc0 read data, combinational from cp0_addr
- exc_commit  in  1  exception taken this cycle
- exc_code  in  5  ExcCode of the taken exception
- exc_bd  in  1  excepting instruction is in a delay slot
- exc_pc  in  32  PC of the excepting instruction
- exc_badv_we  in  1  exception is an address error/TLB fault; latch BadVAddr
- exc_badvaddr  in  32  faulting virtual address
- eret_commit  in  1  eret retired this cycle
- epc_out  out  32  current EPC
- status_exl  out  1  Status.EXL
- int_pending  out  1  unmasked interrupt pending
- tlbp_we  in  1  tlbp result strobe (CP0_TLB_EN only)
- tlbp_found  in  1  tlbp hit
- tlbp_index  in  INDEX_W  tlbp hit index
- tlbr_we  in  1  tlbr result strobe; loads r_* into EntryHi/Lo0/Lo1
- r_vpn2 in 19, r_asid in 8, r_g in 1, r_pfn0 in 20, r_c0 in 3, r_d0 in 1, r_v0 in 1, r_pfn1 in 20, r_c1 in 3, r_d1 in 1, r_v1 in 1: TLB read-port entry
- entryhi_out, entrylo0_out, entrylo1_out  out  32 each  register contents for tlbwi/tlbp
- index_out  out  INDEX_W  Index.Index for tlbwi/tlbr

Behaviour:
Reset values (on reset):
- Status: BEV=1, IM=0, EXL=0, IE=0.
- Cause = 0. EPC = 0. Count = 0. Compare = 0. BadVAddr = 0. Divider = 0.
- EntryHi, EntryLo0, EntryLo1, Index = 0.
- All outputs therefore reset to 0, except cp0_rdata, which shows Status = 0x0040_0000 when addr = 12.

Same-cycle priority (exc_commit > eret_commit > mtc0_we) for EXL, EPC and BD:
- exc_commit: EXL<=1; ExcCode<=exc_code.
- exc_commit with EXL==0: EPC<=exc_bd ? exc_pc-4 : exc_pc; BD<=exc_bd.
- exc_commit with exc_badv_we: BadVAddr<=exc_badvaddr.
- exc_commit suppresses mtc0_we in the same cycle.
- eret_commit (no exception): EXL<=0.

mtc0 writable fields (all other bits read 0):
- Status: IM[15:8], EXL[1], IE[0].
- Cause: IP[9:8].
- EPC, Count, Compare: full 32 bits.
- EntryHi: [31:13], [7:0].
- EntryLo0/1: [25:0].
- Index: [INDEX_W-1:0].
- Writes to BadVAddr and to unimplemented addresses are ignored; unimplemented reads return 0.

Timer:
- Divider counts 0..COUNT_DIV-1; Count+1 on terminal count; Count wraps 0xFFFF_FFFF->0.
- mtc0 Count loads Count and does not touch the divider; the load wins over a same-cycle increment.
- TI set when Count==Compare (registered).
- mtc0 Compare clears TI and loads Compare; clearing wins over a same-cycle match.

Interrupts:
- IP[2+i] <= ext_int[i] every cycle (registered, 1-cycle latency).
- IP[7] additionally ORs in TI.
- IP bits above 2+EXT_INT_W-1, other than IP[7], read 0.
- int_pending = IE & ~EXL & |(IP & IM), combinational.

TLB:
- tlbp_we: Index.P[31]<=~tlbp_found; Index<=tlbp_index when found.
- tlbr_we: EntryHi<={r_vpn2,5'b0,r_asid}; EntryLo0/1<={6'b0,pfn,c,d,v,r_g}.
- tlbr_we has priority over a same-cycle mtc0 to those registers.

Read latency:
- cp0_rdata is combinational; a write is visible on the next cycle.

Optional Feature:
- CP0_TLB_EN defined: EntryHi(10), EntryLo0(2), EntryLo1(3) and Index(0) are implemented; tlbp/tlbr ports are active.
- CP0_TLB_EN undefined: those registers are absent and read 0; tlb inputs are ignored; entry*/index outputs are tied 0.

Decomposition:
- Package cp0_pkg: register address constants (INDEX=0, ENTRYLO0=2, ENTRYLO1=3, BADVADDR=8, COUNT=9, ENTRYHI=10, COMPARE=11, STATUS=12, CAUSE=13, EPC=14), ExcCode constants (INT=0, MOD=1, TLBL=2, TLBS=3, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), Status/Cause field-position constants.
- Sub-module cp0_timer (Count, Compare, divider, TI) with ports: mtc0 count/compare strobes, wdata, count, compare, ti.

Test Plan:
- Reset, then read addr 12 -> 0x0040_0000; addr 13, 14, 9 -> 0.
- COUNT_DIV=2, mtc0 Compare=5 -> Count reaches 5 at cycle ~10; TI=1; IP[7]=1 one cycle later. With Status=0x0000_8001, int_pending=1. mtc0 Compare -> TI=0.
- exc_commit, exc_bd=1, exc_pc=0xBFC0_0104, code 4, exc_badv_we, badvaddr 0x1 -> EPC=0xBFC0_0100, Cause=0x8000_0010, EXL=1, BadVAddr=0x1. Second exception while EXL=1 leaves EPC/BD unchanged.
- exc_commit + eret_commit + mtc0 Status=0 in the same cycle -> EXL=1, Status IE/IM unchanged.
- ext_int=6'b000100 with IM=0x10, IE=1 -> int_pending=1 after 1 cycle. Then eret/exception sequence -> int_pending follows ~EXL.
- CP0_TLB_EN: tlbp_we with found=0 -> Index=0x8000_0000. tlbr_we with r_vpn2=0x7FFFF, r_asid=0x5A -> EntryHi=0xFFFF_E05A.
